// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer sharing one full-adder cell across WIDTH bits.
module fa_structural (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g, t;
  xor (p, a, b);
  xor (s, p, ci);
  and (g, a, b);
  and (t, p, ci);
  or  (co, g, t);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0]    count;
  logic             carry, cin_msb, s_fa, co_fa;
  fa_structural u_fa (
    .a (ra[0]),
    .b (rb[0]),
    .ci(carry),
    .s (s_fa),
    .co(co_fa)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      sum     <= '0;
      count   <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra    <= a;
          rb    <= sub ? ~b : b;
          carry <= sub;
          count <= '0;
          state <= RUN;
        end
        RUN: begin
          sum   <= {s_fa, sum[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= co_fa;
          count <= (count == LAST) ? count : count + 1'b1;
          // carry entering the MSB is kept for the signed overflow test
          if (count == LAST) begin
            cin_msb <= carry;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign co        = carry;
  assign ovf       = cin_msb ^ carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench against an arithmetic reference model.
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, co, ovf, busy;
  logic [7:0] sum;
  int         n_cmp = 0, n_err = 0, cyc = 0, last_acc = -100;
  logic [7:0] exp_s;
  logic       exp_c, exp_o;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int r, sr;
    r  = s ? int'(x) - int'(y) : int'(x) + int'(y);
    sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    exp_s = r[7:0];
    exp_c = s ? (x >= y) : (r > 255);
    exp_o = (sr > 127) || (sr < -128);
  endfunction

  task automatic scramble();
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
  endtask

  // called at a negedge; returns at the negedge just after the acceptance edge
  task automatic start(input logic [7:0] x, input logic [7:0] y, input logic s, input bit b2b);
    int k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk("in_ready_wait", in_ready, 1);
    a = x; b = y; sub = s; in_valid = 1'b1;
    model(x, y, s);
    if (b2b) chk("throughput", cyc + 1 - last_acc, 10);
    last_acc = cyc + 1;
    @(negedge clk);
    chk("run_in_ready", in_ready, 0);
    chk("run_busy", busy, 1);
  endtask

  task automatic run_bits(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      scramble();
      if (i < 8) begin
        out_ready = 1'($urandom);
        chk("run_out_valid", out_valid, 0);
      end else begin
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("latency_out_valid", out_valid, 1);
      end
    end
  endtask

  task automatic finish(input int bp, input logic [7:0] nx, input logic [7:0] ny, input logic ns);
    chk("sum", sum, exp_s);
    chk("co", co, exp_c);
    chk("ovf", ovf, exp_o);
    for (int i = 0; i < bp; i++) begin
      a = nx; b = ny; sub = ns; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, exp_s);
      chk("bp_co", co, exp_c);
      chk("bp_ovf", ovf, exp_o);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("handoff_busy", busy, 0);
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s, input bit b2b);
    start(x, y, s, b2b);
    run_bits(8);
    finish(0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk({tag, "_rst_in_ready"}, in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_co"}, co, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_co", co, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    op(8'h35, 8'h4A, 1'b0, 0);
    op(8'hFF, 8'h01, 1'b0, 1);
    op(8'h7F, 8'h01, 1'b0, 1);
    op(8'h05, 8'h07, 1'b1, 1);
    op(8'h80, 8'h01, 1'b1, 1);
    op(8'h22, 8'h22, 1'b1, 1);
    start(8'h9C, 8'h3B, 1'b1, 1);
    run_bits(8);
    finish(5, 8'hA5, 8'h5A, 1'b0);
    op(8'hA5, 8'h5A, 1'b0, 0);
    for (int i = 0; i < 40; i++) op(8'($urandom), 8'($urandom), 1'($urandom), 1);
    start(8'h44, 8'h11, 1'b0, 0);
    run_bits(3);
    do_reset("rst_run");
    op(8'h10, 8'h20, 1'b0, 0);
    start(8'hC3, 8'h3C, 1'b1, 0);
    run_bits(8);
    do_reset("rst_done");
    op(8'h10, 8'h20, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
